mux_sel_reg: RTL and testbench
==============================

MUX_SEL_REG -- requirements
Module: mux_sel_reg

Interface
REQ-001 Parameter WIDTH, default 5, data width of each channel and of the result.
REQ-002 Parameter NCH, default 4, channel count; legal range 2..16.
REQ-003 Parameter DEFAULT_VAL, default 0, WIDTH-bit value used for illegal select codes.
REQ-004 Derived SW = ceil(log2(NCH)), select width.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 din  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-009 sel  input  SW  channel select.
REQ-010 ld  input  1  load request: capture the selected channel this cycle.
REQ-011 ack  input  1  consumer has taken the registered result.
REQ-012 r_comb  output  WIDTH  combinational selected value, no storage.
REQ-013 r  output  WIDTH  registered result.
REQ-014 r_valid  output  1  r holds an unconsumed result.
REQ-015 busy  output  1  load would be refused this cycle.
REQ-016 err_sel  output  1  sticky: an illegal select was loaded.
REQ-017 err_ovf  output  1  sticky: a load was refused.
REQ-018 ld_cnt  output  8  count of accepted loads, wrapping.

Function
REQ-019 r_comb SHALL equal channel sel when sel < NCH, else DEFAULT_VAL; no latch for any sel code.
REQ-020 busy SHALL equal r_valid AND NOT ack (combinational).
REQ-021 Load accepted when ld=1 and busy=0; on that edge r <= r_comb, r_valid <= 1, ld_cnt <= ld_cnt+1 modulo 256.
REQ-022 Load latency: r SHALL show the captured value one cycle after the accepting edge; r_comb has zero latency.
REQ-023 Refused load (ld=1, busy=1): r, r_valid, ld_cnt SHALL be unchanged; err_ovf SHALL set on that edge.
REQ-024 ack with r_valid=1 and no accepted load: r_valid <= 0; r SHALL hold its last value.
REQ-025 ack and ld in same cycle with r_valid=1: load accepted, r_valid stays 1, r takes the new value (back-to-back throughput of one per cycle).
REQ-026 ack with r_valid=0 SHALL be ignored.
REQ-027 Accepted load with sel >= NCH SHALL capture DEFAULT_VAL and set err_sel on that edge.
REQ-028 err_sel and err_ovf SHALL remain set until reset; no other clear.
REQ-029 Without ld or ack, all registered outputs SHALL hold.
REQ-030 State machine, two states: EMPTY (r_valid=0) and FULL (r_valid=1); EMPTY->FULL on accepted load; FULL->EMPTY on ack without ld; FULL->FULL on ld with ack, or on idle/refused load.
REQ-031 When NCH is a power of two, illegal select SHALL be unreachable and err_sel SHALL stay 0.

Reset
REQ-032 On rst assertion, immediately and independent of clk: r=DEFAULT_VAL, r_valid=0, err_sel=0, err_ovf=0, ld_cnt=0.
REQ-033 rst asserted mid-operation SHALL discard any pending result; a ld sampled on the edge where rst is high SHALL be ignored.
REQ-034 First load SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-035 WIDTH=5, NCH=4, din channels 0x01,0x02,0x04,0x08; sweep sel 0..3 -> r_comb 0x01,0x02,0x04,0x08 same cycle.
REQ-036 ld with sel=2, idle next cycle, then ack -> r=0x04, r_valid=1 one cycle after load; r_valid=0 after ack; r stays 0x04; ld_cnt=1.
REQ-037 NCH=3, ld with sel=3, DEFAULT_VAL=0x1F -> r=0x1F, err_sel=1 and stays 1 across later legal loads.
REQ-038 r_valid=1, ld without ack -> busy=1, r unchanged, err_ovf=1, ld_cnt unchanged; then ld with ack same cycle -> new value captured, r_valid stays 1.
REQ-039 256 back-to-back loads with ack held high -> ld_cnt wraps to 0, r_valid continuously 1 after first load.
REQ-040 rst pulsed between clock edges while r_valid=1, err_ovf=1 -> all outputs at reset values before next edge; ld held high across rst deassert -> accepted on first edge after.

Source files
------------

// File: rtl/mux_sel_reg.sv
// mux_sel_reg: NCH-way WIDTH-bit channel select with a one-deep registered
// result, EMPTY/FULL consume handshake, sticky error flags and a load counter.
module mux_sel_reg #(
  parameter int unsigned      WIDTH       = 5,
  parameter int unsigned      NCH         = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}},
  localparam int unsigned     SW          = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SW-1:0]        sel,
  input  logic                 ld,
  input  logic                 ack,
  output logic [WIDTH-1:0]     r_comb,
  output logic [WIDTH-1:0]     r,
  output logic                 r_valid,
  output logic                 busy,
  output logic                 err_sel,
  output logic                 err_ovf,
  output logic [7:0]           ld_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             esel_q, esel_d;
  logic             eovf_q, eovf_d;
  logic [WIDTH-1:0] mux_s;
  logic             sel_legal_s;
  logic             busy_s;
  logic             accept_s;

  // Channel select; codes with no matching channel fall back to DEFAULT_VAL.
  always_comb begin
    mux_s       = DEFAULT_VAL;
    sel_legal_s = 1'b0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (sel == SW'(k)) begin
        mux_s       = din[k*WIDTH +: WIDTH];
        sel_legal_s = 1'b1;
      end else begin
        mux_s       = mux_s;
        sel_legal_s = sel_legal_s;
      end
    end
  end

  assign busy_s   = (state_q == FULL) && !ack;
  assign accept_s = ld && !busy_s;

  // Next-state logic of the EMPTY/FULL holding register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) state_d = FULL;
        else          state_d = EMPTY;
      end
      FULL: begin
        if (ack && !ld) state_d = EMPTY;
        else            state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Result capture, load counting and sticky error flags.
  always_comb begin
    r_d    = r_q;
    cnt_d  = cnt_q;
    esel_d = esel_q;
    eovf_d = eovf_q;
    if (accept_s) begin
      r_d    = mux_s;
      cnt_d  = cnt_q + 8'd1;
      esel_d = esel_q | ~sel_legal_s;
    end else begin
      r_d    = r_q;
      cnt_d  = cnt_q;
      esel_d = esel_q;
    end
    if (ld && busy_s) eovf_d = 1'b1;
    else              eovf_d = eovf_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      r_q     <= DEFAULT_VAL;
      cnt_q   <= 8'd0;
      esel_q  <= 1'b0;
      eovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      esel_q  <= esel_d;
      eovf_q  <= eovf_d;
    end
  end

  assign r_comb  = mux_s;
  assign r       = r_q;
  assign r_valid = (state_q == FULL);
  assign busy    = busy_s;
  assign err_sel = esel_q;
  assign err_ovf = eovf_q;
  assign ld_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Scoreboard bench for mux_sel_reg: a 3-channel instance (illegal code
// exercised) and a 4-channel instance (every code legal) share controls.
module tb_mux_sel_reg;

  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [14:0]   din3 = 15'd0;
  logic [19:0]   din4 = 20'd0;
  logic [1:0]    sel = 2'd0;
  logic          ld = 1'b1;
  logic          ack = 1'b0;

  logic [W-1:0]  r_comb3, r3, r_comb4, r4;
  logic          r_valid3, busy3, err_sel3, err_ovf3;
  logic          r_valid4, busy4, err_sel4, err_ovf4;
  logic [7:0]    ld_cnt3, ld_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  mux_sel_reg #(.WIDTH(5), .NCH(3), .DEFAULT_VAL(5'h1F)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel), .ld(ld), .ack(ack),
    .r_comb(r_comb3), .r(r3), .r_valid(r_valid3), .busy(busy3),
    .err_sel(err_sel3), .err_ovf(err_ovf3), .ld_cnt(ld_cnt3)
  );

  mux_sel_reg #(.WIDTH(5), .NCH(4), .DEFAULT_VAL(5'h00)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .sel(sel), .ld(ld), .ack(ack),
    .r_comb(r_comb4), .r(r4), .r_valid(r_valid4), .busy(busy4),
    .err_sel(err_sel4), .err_ovf(err_ovf4), .ld_cnt(ld_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int comb3;
    int comb4;
    int busy;
    int r;
    int valid;
    int esel;
    int eovf;
    int cnt;
  } item_t;

  item_t sb_q[$];

  // Reference model of the 3-channel instance, as plain state variables.
  int m_valid, m_r, m_cnt, m_esel, m_eovf;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_r = 'h1F; m_cnt = 0; m_esel = 0; m_eovf = 0;
  endfunction

  function automatic int chan3(input int s);
    if (s < 3) return (int'(din3) >> (s * 5)) % 32;
    else       return 'h1F;
  endfunction

  function automatic int chan4(input int s);
    return (int'(din4) >> (s * 5)) % 32;
  endfunction

  // Apply one cycle of inputs now and queue what both DUTs must show.
  task automatic drive_now(input int l, input int a, input int s);
    item_t it;
    int    b;
    ld  = (l != 0);
    ack = (a != 0);
    sel = 2'(s);
    b   = (m_valid == 1 && a == 0) ? 1 : 0;
    it.comb3 = chan3(s);
    it.comb4 = chan4(s);
    it.busy  = b;
    if (l != 0 && b == 0) begin
      m_r     = chan3(s);
      m_valid = 1;
      m_cnt   = (m_cnt + 1) % 256;
      if (s >= 3) m_esel = 1;
    end else begin
      if (l != 0) m_eovf = 1;
      if (a != 0 && m_valid == 1) m_valid = 0;
    end
    it.r = m_r; it.valid = m_valid; it.esel = m_esel;
    it.eovf = m_eovf; it.cnt = m_cnt;
    sb_q.push_back(it);
  endtask

  task automatic drive(input int l, input int a, input int s);
    @(negedge clk);
    drive_now(l, a, s);
  endtask

  // Monitor: combinational outputs before the edge, registered ones after it.
  initial begin
    item_t it;
    forever begin
      @(negedge clk); #2;
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        chk("r_comb3", int'(r_comb3), it.comb3);
        chk("r_comb4", int'(r_comb4), it.comb4);
        chk("busy", int'(busy3), it.busy);
        @(posedge clk); #1;
        chk("r", int'(r3), it.r);
        chk("r_valid", int'(r_valid3), it.valid);
        chk("err_sel", int'(err_sel3), it.esel);
        chk("err_ovf", int'(err_ovf3), it.eovf);
        chk("ld_cnt", int'(ld_cnt3), it.cnt);
        chk("err_sel4", int'(err_sel4), 0);
      end
    end
  end

  initial begin
    model_reset();
    din3 = {5'h04, 5'h02, 5'h01};
    din4 = {5'h08, 5'h04, 5'h02, 5'h01};
    // ld held high while reset is asserted over two edges must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r", int'(r3), 'h1F);
    chk("rst_valid", int'(r_valid3), 0);
    chk("rst_cnt", int'(ld_cnt3), 0);
    chk("rst_r4", int'(r4), 0);
    rst = 1'b0;
    drive_now(1, 0, 2);          // first edge after reset: accepted
    drive(0, 0, 0);
    drive(0, 1, 0);
    drive(0, 0, 0);
    for (int s = 0; s < 4; s++) drive(0, 0, s);
    drive(0, 1, 0);              // ack while empty is ignored
    drive(1, 0, 3);              // illegal code on the 3-channel part
    drive(0, 1, 0);
    drive(1, 0, 1);
    drive(1, 0, 0);              // refused
    drive(1, 1, 0);              // accepted with ack
    for (int i = 0; i < 256; i++) drive(1, 1, $urandom_range(0, 3));
    drive(1, 0, 2);              // refused: valid=1 and err_ovf=1 from here
    // Asynchronous reset pulse strictly between edges, ld held high across it.
    @(posedge clk); #2;
    ld  = 1'b1;
    ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_r", int'(r3), 'h1F);
    chk("arst_valid", int'(r_valid3), 0);
    chk("arst_busy", int'(busy3), 0);
    chk("arst_err_sel", int'(err_sel3), 0);
    chk("arst_err_ovf", int'(err_ovf3), 0);
    chk("arst_cnt", int'(ld_cnt3), 0);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din3 = 15'($urandom);
      din4 = 20'($urandom);
      drive_now(($urandom_range(0, 99) < 60) ? 1 : 0,
                ($urandom_range(0, 99) < 50) ? 1 : 0,
                $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d items left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
